// File: rtl/interrupt_controller_pkg.sv
// Shared types and helpers for the Mini SRC interrupt controller.
package minisrc_int_pkg;

  localparam int MAX_IRQ = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // Lowest set index wins, so lower line numbers have higher priority.
  function automatic logic [3:0] prio_encode(input logic [MAX_IRQ-1:0] vec);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt controller (slave) and the control unit side (master).
interface interrupt_controller_if #(
  parameter int N  = 2,
  parameter int VW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]  IrqIn;
  logic          MaskWrite;
  logic [N-1:0]  MaskData;
  logic          IntAck;
  logic          IntDone;
  logic          IntReq;
  logic [VW-1:0] IntVector;
  logic [31:0]   IntAddr;
  logic          IntActive;
  logic [N-1:0]  Pending;
  logic [N-1:0]  Mask;

  modport master (
    output IrqIn, MaskWrite, MaskData, IntAck, IntDone,
    input  IntReq, IntVector, IntAddr, IntActive, Pending, Mask
  );

  modport slave (
    input  IrqIn, MaskWrite, MaskData, IntAck, IntDone,
    output IntReq, IntVector, IntAddr, IntActive, Pending, Mask
  );
endinterface

// File: rtl/interrupt_controller_irq_edge_sync.sv
// Per-line rising-edge detector; IRQ_SYNC_EN adds a two-flop synchronizer in front.
module irq_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic irq_i,
  output logic event_o
);
  logic sync_s;
  logic prev_q;

`ifdef IRQ_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer for lines asynchronous to the clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign sync_s = sync2_q;
`else
  assign sync_s = irq_i;
`endif

  // Edge history: previous synchronized level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync_s;
    end
  end

  assign event_o = sync_s & ~prev_q;
endmodule

// File: rtl/interrupt_controller.sv
// Prioritised, maskable interrupt controller with req/ack/done handshake.
// Optional input synchronizer selected by macro IRQ_SYNC_EN.
module interrupt_controller
  import minisrc_int_pkg::*;
#(
  parameter int                       InterruptsNum = 2,
  parameter logic [31:0]              VECTOR_BASE   = 32'h0000_0100,
  parameter logic [31:0]              VECTOR_STRIDE = 32'h0000_0010,
  parameter logic [InterruptsNum-1:0] MASK_RESET    = {InterruptsNum{1'b1}}
) (
  input logic                   Clock,
  input logic                   Reset,
  interrupt_controller_if.slave bus
);
  localparam int N  = InterruptsNum;
  localparam int VW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       event_s;
  logic [N-1:0]       ack_clr_s;
  logic [N-1:0]       pending_d, pending_q;
  logic [N-1:0]       mask_d, mask_q;
  logic [MAX_IRQ-1:0] req_vec_s;
  logic [3:0]         enc_s;
  state_e             state_q;
  logic               req_q, active_q;
  logic [VW-1:0]      vec_q;
  logic [31:0]        addr_q;

  for (genvar g = 0; g < N; g++) begin : g_line
    irq_edge_sync u_edge (
      .clk_i  (Clock),
      .rst_i  (Reset),
      .irq_i  (bus.IrqIn[g]),
      .event_o(event_s[g])
    );
  end

  // Pending/mask next state: a new event outranks the ack clear on the same bit.
  always_comb begin
    ack_clr_s = '0;
    if ((state_q == REQ) && bus.IntAck) begin
      ack_clr_s[vec_q] = 1'b1;
    end else begin
      ack_clr_s = '0;
    end
    pending_d = (pending_q & ~ack_clr_s) | event_s;
    if (bus.MaskWrite) begin
      mask_d = bus.MaskData;
    end else begin
      mask_d = mask_q;
    end
    req_vec_s        = '0;
    req_vec_s[N-1:0] = pending_q & mask_q;
    enc_s            = prio_encode(req_vec_s);
  end

  // Pending and mask registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pending_q <= '0;
      mask_q    <= MASK_RESET;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  // Handshake FSM with registered request, vector and address outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      active_q <= 1'b0;
      vec_q    <= '0;
      addr_q   <= VECTOR_BASE;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_vec_s) begin
            vec_q   <= enc_s[VW-1:0];
            addr_q  <= VECTOR_BASE + ({28'd0, enc_s} * VECTOR_STRIDE);
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (bus.IntAck) begin
            req_q    <= 1'b0;
            active_q <= 1'b1;
            state_q  <= SERVICE;
          end
        end
        SERVICE: begin
          if (bus.IntDone) begin
            active_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          req_q    <= 1'b0;
          active_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.IntReq    = req_q;
  assign bus.IntVector = vec_q;
  assign bus.IntAddr   = addr_q;
  assign bus.IntActive = active_q;
  assign bus.Pending   = pending_q;
  assign bus.Mask      = mask_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_interrupt_controller;
  localparam int PERIOD = 10;
`ifdef IRQ_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  localparam int LAT = D + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  interrupt_controller_if #(.N(2)) bus ();

  interrupt_controller #(.InterruptsNum(2)) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #(PERIOD / 2) clk = ~clk;

  // Model state: pending/mask sets, handshake phase (0 idle, 1 requesting, 2 servicing).
  logic [1:0] m_pend  = 2'b00;
  logic [1:0] m_mask  = 2'b11;
  int         m_phase = 0;
  int         m_vec   = 0;
  logic [1:0] hist [0:3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend  = 2'b00;
    m_mask  = 2'b11;
    m_phase = 0;
    m_vec   = 0;
    for (int i = 0; i < 4; i++) hist[i] = 2'b00;
  endtask

  // An event for line i reaches Pending D samples after the line was seen rising.
  task automatic model_step();
    logic [1:0] ev, clr, avail;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = bus.IrqIn;
    ev    = hist[D] & ~hist[D+1];
    clr   = 2'b00;
    avail = m_pend & m_mask;
    if (m_phase == 0) begin
      if (avail != 2'b00) begin
        for (int i = 1; i >= 0; i--) if (avail[i]) m_vec = i;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (bus.IntAck) begin
        clr[m_vec] = 1'b1;
        m_phase    = 2;
      end
    end else begin
      if (bus.IntDone) m_phase = 0;
    end
    m_pend = (m_pend & ~clr) | ev;
    if (bus.MaskWrite) m_mask = bus.MaskData;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_IntReq",    {31'd0, bus.IntReq},    (m_phase == 1) ? 32'd1 : 32'd0);
      chk("m_IntActive", {31'd0, bus.IntActive}, (m_phase == 2) ? 32'd1 : 32'd0);
      chk("m_IntVector", {31'd0, bus.IntVector}, 32'(m_vec));
      chk("m_IntAddr",   bus.IntAddr,            32'h100 + 32'(m_vec) * 32'h10);
      chk("m_Pending",   {30'd0, bus.Pending},   {30'd0, m_pend});
      chk("m_Mask",      {30'd0, bus.Mask},      {30'd0, m_mask});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int maxc, input string nm);
    int c;
    c = 0;
    while (!bus.IntReq && c < maxc) begin
      step(1);
      c++;
    end
    chk(nm, {31'd0, bus.IntReq}, 32'd1);
  endtask

  task automatic pulse_ack();
    bus.IntAck = 1'b1;
    step(1);
    bus.IntAck = 1'b0;
  endtask

  task automatic pulse_done();
    bus.IntDone = 1'b1;
    step(1);
    bus.IntDone = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_IntReq"},    {31'd0, bus.IntReq},    32'd0);
    chk({tag, "_IntVector"}, {31'd0, bus.IntVector}, 32'd0);
    chk({tag, "_IntAddr"},   bus.IntAddr,            32'h100);
    chk({tag, "_IntActive"}, {31'd0, bus.IntActive}, 32'd0);
    chk({tag, "_Pending"},   {30'd0, bus.Pending},   32'd0);
    chk({tag, "_Mask"},      {30'd0, bus.Mask},      32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bus.IrqIn = 2'b00; bus.MaskWrite = 1'b0; bus.MaskData = 2'b00;
    bus.IntAck = 1'b0; bus.IntDone = 1'b0;
    @(negedge clk);
    check_reset_values("rst");
    @(posedge clk); #1 rst = 1'b0;
    step(2);

    // Single event on line 0, held high.
    bus.IrqIn = 2'b01;
    c = 0;
    while (!bus.IntReq && c < 10) begin
      step(1);
      c++;
    end
    chk("t1_latency", 32'(c), 32'(LAT));
    chk("t1_vector", {31'd0, bus.IntVector}, 32'd0);
    chk("t1_addr", bus.IntAddr, 32'h100);
    pulse_ack();
    chk("t1_pending", {30'd0, bus.Pending}, 32'd0);
    chk("t1_active", {31'd0, bus.IntActive}, 32'd1);
    chk("t1_req_dropped", {31'd0, bus.IntReq}, 32'd0);
    step(6);
    pulse_done();
    step(LAT + 2);
    chk("t1_no_rereq", {31'd0, bus.IntReq}, 32'd0);
    bus.IrqIn = 2'b00;
    step(3);

    // Both lines rise together: line 0 first, then line 1.
    bus.IrqIn = 2'b11;
    wait_req(10, "t2_req0");
    chk("t2_vec0", {31'd0, bus.IntVector}, 32'd0);
    chk("t2_addr0", bus.IntAddr, 32'h100);
    pulse_ack();
    chk("t2_pending", {30'd0, bus.Pending}, 32'd2);
    pulse_done();
    wait_req(4, "t2_req1");
    chk("t2_vec1", {31'd0, bus.IntVector}, 32'd1);
    chk("t2_addr1", bus.IntAddr, 32'h110);
    pulse_ack();
    pulse_done();
    bus.IrqIn = 2'b00;
    step(3);

    // Masked line 0 stays pending until unmasked.
    bus.MaskWrite = 1'b1; bus.MaskData = 2'b10;
    step(1);
    bus.MaskWrite = 1'b0;
    chk("t3_mask", {30'd0, bus.Mask}, 32'd2);
    bus.IrqIn = 2'b01;
    step(1);
    bus.IrqIn = 2'b00;
    step(LAT + 3);
    chk("t3_pending", {30'd0, bus.Pending}, 32'd1);
    chk("t3_no_req", {31'd0, bus.IntReq}, 32'd0);
    bus.MaskWrite = 1'b1; bus.MaskData = 2'b11;
    step(1);
    bus.MaskWrite = 1'b0;
    wait_req(2, "t3_unmask_req");
    pulse_ack();

    // New event while servicing only accumulates.
    bus.IrqIn = 2'b01;
    step(1);
    bus.IrqIn = 2'b00;
    step(LAT + 2);
    chk("t4_pending", {30'd0, bus.Pending}, 32'd1);
    chk("t4_no_req", {31'd0, bus.IntReq}, 32'd0);
    chk("t4_active", {31'd0, bus.IntActive}, 32'd1);
    pulse_done();
    wait_req(3, "t4_rereq");
    chk("t4_vec", {31'd0, bus.IntVector}, 32'd0);

    // Event lands on the same edge as the ack clearing line 0.
    bus.IrqIn = 2'b01;
    step(D);
    pulse_ack();
    chk("t5_pending_kept", {30'd0, bus.Pending}, 32'd1);
    chk("t5_active", {31'd0, bus.IntActive}, 32'd1);
    pulse_done();
    wait_req(3, "t5_rereq");

    // Committed request survives a mask change; async reset mid-handshake.
    bus.MaskWrite = 1'b1; bus.MaskData = 2'b00;
    step(1);
    bus.MaskWrite = 1'b0;
    step(2);
    chk("t6_committed", {31'd0, bus.IntReq}, 32'd1);
    chk("t6_mask0", {30'd0, bus.Mask}, 32'd0);
    #2 rst = 1'b1;
    #1 check_reset_values("t6_async");
    bus.IrqIn = 2'b00;
    @(posedge clk); #1 rst = 1'b0;
    step(2);

    // Random traffic, including protocol errors.
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(3, 0) == 0) bus.IrqIn[b] = ~bus.IrqIn[b];
      end
      bus.MaskWrite = ($urandom_range(9, 0) == 0);
      bus.MaskData  = 2'($urandom_range(3, 0));
      bus.IntAck    = ($urandom_range(2, 0) == 0);
      bus.IntDone   = ($urandom_range(3, 0) == 0);
      step(1);
    end
    bus.IrqIn = 2'b00; bus.MaskWrite = 1'b0; bus.IntAck = 1'b0; bus.IntDone = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
